// File: rtl/quas_pkg.sv
// Shared definitions for the Q-learning action selector: Q16.16 constants,
// selector FSM states and the LFSR polynomial/seed.
package quas_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int Q_FRAC_BITS = 16;

    localparam logic signed [DATA_WIDTH-1:0] Q_ZERO = 32'sh0000_0000;
    localparam logic signed [DATA_WIDTH-1:0] Q_ONE  = 32'sh0001_0000;
    localparam logic signed [DATA_WIDTH-1:0] Q_MAX  = 32'sh7FFF_FFFF;
    localparam logic signed [DATA_WIDTH-1:0] Q_MIN  = 32'sh8000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SELECT = 2'd2,
        OUT    = 2'd3
    } sel_state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // One right shift of the Galois LFSR; the feedback bit is the LSB shifted out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances every cycle; a reseed pulse replaces that
// cycle's shift, and an all-zero seed is swapped for the default seed.
module lfsr16
    import quas_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    always_comb begin
        lfsr_next = lfsr_step(lfsr_reg);
        if (seed_load) begin
            // All-zero state would lock the LFSR up
            lfsr_next = (seed == 16'h0000) ? LFSR_SEED : seed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign lfsr = lfsr_reg;

endmodule

// File: rtl/action_selector.sv
// Epsilon-greedy action selector: fetches a Q-row, picks argmax or a random action.
// Optional epsilon decay register enabled by ACTION_SELECTOR_EPS_DECAY_EN.
module action_selector #(
    parameter int          NUM_STATES   = 16,
    parameter int          NUM_ACTIONS  = 4,
    parameter int          DATA_WIDTH   = quas_pkg::DATA_WIDTH,
    parameter int          DECAY_SHIFT  = 8,
    parameter logic [15:0] EPS_MIN      = 16'h0100,
    localparam int         STATE_WIDTH  = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
    localparam int         ACTION_WIDTH = $clog2(NUM_ACTIONS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [STATE_WIDTH-1:0]             req_state,
    input  logic [15:0]                        epsilon,
    input  logic                               eps_load,
    input  logic                               seed_load,
    input  logic [15:0]                        seed,
    output logic                               q_rd_en,
    output logic [STATE_WIDTH-1:0]             q_rd_state,
    input  logic [NUM_ACTIONS*DATA_WIDTH-1:0]  q_rd_data,
    output logic                               act_valid,
    input  logic                               act_ready,
    output logic [STATE_WIDTH-1:0]             act_state,
    output logic [ACTION_WIDTH-1:0]            act_action,
    output logic                               act_explore
);
    import quas_pkg::*;

    sel_state_t state_reg, state_next;

    logic [STATE_WIDTH-1:0]  cap_state_reg;
    logic [STATE_WIDTH-1:0]  act_state_reg;
    logic [ACTION_WIDTH-1:0] act_action_reg;
    logic                    act_explore_reg;
    logic [15:0]             lfsr;
    logic [15:0]             eps_eff;
    logic                    accept;
    logic                    act_handshake;

    lfsr16 u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .lfsr      (lfsr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        q_rd_en    = 1'b0;
        act_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = FETCH;
            end
            FETCH: begin
                q_rd_en    = 1'b1;
                state_next = SELECT;
            end
            SELECT: state_next = OUT;
            OUT: begin
                act_valid = 1'b1;
                if (act_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept        = (state_reg == IDLE) && req_valid;
    assign act_handshake = (state_reg == OUT) && act_ready;
    assign q_rd_state    = cap_state_reg;

`ifdef ACTION_SELECTOR_EPS_DECAY_EN
    logic [15:0] eps_reg;
    logic [15:0] eps_dec;

    assign eps_dec = eps_reg - (eps_reg >> DECAY_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eps_reg <= 16'hFFFF;
        end else if (eps_load) begin
            eps_reg <= epsilon;
        end else if (act_handshake) begin
            eps_reg <= (eps_dec < EPS_MIN) ? EPS_MIN : eps_dec;
        end
    end

    assign eps_eff = eps_reg;
`else
    logic [15:0] eps_cap_reg;
    logic        unused_cfg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eps_cap_reg <= 16'h0000;
        end else if (accept) begin
            eps_cap_reg <= epsilon;
        end
    end

    assign eps_eff    = eps_cap_reg;
    assign unused_cfg = ^{eps_load, act_handshake, EPS_MIN, 32'(DECAY_SHIFT)};
`endif

    // Signed argmax; strict compare keeps the lowest index on ties
    logic signed [DATA_WIDTH-1:0] q_vals [NUM_ACTIONS];
    logic signed [DATA_WIDTH-1:0] best_val;
    logic [ACTION_WIDTH-1:0]      greedy_action;
    logic                         explore;

    generate
        for (genvar gi = 0; gi < NUM_ACTIONS; gi++) begin : g_unpack
            assign q_vals[gi] = q_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        best_val      = q_vals[0];
        greedy_action = '0;
        for (int i = 1; i < NUM_ACTIONS; i++) begin
            if (q_vals[i] > best_val) begin
                best_val      = q_vals[i];
                greedy_action = ACTION_WIDTH'(i);
            end
        end
    end

    assign explore = (lfsr < eps_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_state_reg   <= '0;
            act_state_reg   <= '0;
            act_action_reg  <= '0;
            act_explore_reg <= 1'b0;
        end else begin
            if (accept) cap_state_reg <= req_state;
            if (state_reg == SELECT) begin
                act_state_reg   <= cap_state_reg;
                act_action_reg  <= explore ? lfsr[15 -: ACTION_WIDTH] : greedy_action;
                act_explore_reg <= explore;
            end
        end
    end

    assign act_state   = act_state_reg;
    assign act_action  = act_action_reg;
    assign act_explore = act_explore_reg;

endmodule
